// File: rtl/abs_result_fifo.sv
// abs_result_fifo: first-word-fall-through result FIFO behind the absolute-value unit,
// with sticky status, overflow flag and saturating accepted-result counter.
`default_nettype none

module abs_result_fifo #(
  parameter int m     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [m-1:0]               i_newB,
  input  logic [3:0]                 i_status,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [m-1:0]               o_result,
  output logic [3:0]                 o_status,
  output logic [3:0]                 o_sticky,
  output logic                       o_overflow,
  input  logic                       i_clr_sticky,
  output logic [CNT_W-1:0]           o_count,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = m + 4;
  localparam logic [LW-1:0]    C_DEPTH   = LW'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_nxt;
  logic          valid_q;
  logic          ready_q;
  logic          push;
  logic          pop;
  logic          ovf_cond;
  logic [EW-1:0] head;

  // Full blocks the push even when a pop happens in the same cycle, so
  // ready depends on registered state only.
  assign push     = i_valid && ready_q;
  assign pop      = valid_q && i_ready;
  assign ovf_cond = i_valid && !ready_q;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LW'(1);
    else if (!push && pop)
      level_nxt = level - LW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      level   <= level_nxt;
      valid_q <= (level_nxt != '0);
      ready_q <= (level_nxt < C_DEPTH);
    end
  end

  // Storage is deliberately not reset; the output mux hides stale contents.
  always_ff @(posedge i_clk) begin
    if (push)
      mem[wptr] <= {i_status, i_newB};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sticky   <= '0;
      o_overflow <= 1'b0;
      o_count    <= '0;
    end else if (i_clr_sticky) begin
      o_sticky   <= push ? i_status : 4'b0000;
      o_count    <= push ? CNT_W'(1) : '0;
      o_overflow <= ovf_cond;
    end else begin
      if (push) begin
        o_sticky <= o_sticky | i_status;
        if (o_count != C_CNT_MAX)
          o_count <= o_count + CNT_W'(1);
      end
      if (ovf_cond)
        o_overflow <= 1'b1;
    end
  end

  assign head     = mem[rptr];
  assign o_valid  = valid_q;
  assign o_ready  = ready_q;
  assign o_level  = level;
  assign o_result = valid_q ? head[m-1:0]  : '0;
  assign o_status = valid_q ? head[EW-1:m] : 4'b0000;

endmodule

`default_nettype wire
